// File: rtl/y86_pkg.sv
// Y86-64 shared constants: widths, instruction codes, status codes, ALU and condition functions.
package y86_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned REG_W  = 4;
  localparam logic [REG_W-1:0] RNONE = 4'hF;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] AOK = 4'h1;
  localparam logic [3:0] HLT = 4'h2;
  localparam logic [3:0] ADR = 4'h3;
  localparam logic [3:0] INS = 4'h4;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == HLT) || (stat == ADR) || (stat == INS);
  endfunction

  function automatic logic cond_eval(input logic [3:0] ifun, input logic zf, input logic sf,
                                     input logic of);
    case (ifun)
      C_YES:   return 1'b1;
      C_LE:    return (sf ^ of) | zf;
      C_L:     return sf ^ of;
      C_E:     return zf;
      C_NE:    return ~zf;
      C_GE:    return ~(sf ^ of);
      C_G:     return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: B+A, B-A, A&B, A^B with zero/sign/overflow flags.
module y86_alu
  import y86_pkg::*;
(
  input  logic [WORD_W-1:0] i_alu_a,
  input  logic [WORD_W-1:0] i_alu_b,
  input  logic [3:0]        i_alufun,
  output logic [WORD_W-1:0] o_result,
  output logic              o_zf,
  output logic              o_sf,
  output logic              o_of
);

  localparam int unsigned MSB = WORD_W - 1;

  logic [WORD_W-1:0] w_res;
  logic              w_of;

  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (i_alufun)
      ALU_ADD: begin
        w_res = i_alu_b + i_alu_a;
        w_of  = (i_alu_a[MSB] == i_alu_b[MSB]) && (w_res[MSB] != i_alu_a[MSB]);
      end
      ALU_SUB: begin
        w_res = i_alu_b - i_alu_a;
        w_of  = (i_alu_b[MSB] != i_alu_a[MSB]) && (w_res[MSB] != i_alu_b[MSB]);
      end
      ALU_AND: w_res = i_alu_a & i_alu_b;
      ALU_XOR: w_res = i_alu_a ^ i_alu_b;
      default: ;
    endcase
  end

  assign o_result = w_res;
  assign o_zf     = (w_res == '0);
  assign o_sf     = w_res[MSB];
  assign o_of     = w_of;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and cmov destination override.
// Define EXEC_PERF_CNT_EN to build the bubble and CC-write performance counters.
module execute_stage
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [WORD_W-1:0] d_valC,
  input  logic [WORD_W-1:0] d_valA,
  input  logic [WORD_W-1:0] d_valB,
  input  logic [REG_W-1:0]  d_dstE,
  input  logic [REG_W-1:0]  d_dstM,
  input  logic [REG_W-1:0]  d_srcA,
  input  logic [REG_W-1:0]  d_srcB,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic [3:0]        m_stat,
  input  logic [3:0]        W_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [3:0]        E_stat,
  output logic [WORD_W-1:0] E_valA,
  output logic [REG_W-1:0]  E_dstM,
  output logic [REG_W-1:0]  E_srcA,
  output logic [REG_W-1:0]  E_srcB,
  output logic [WORD_W-1:0] e_valE,
  output logic [REG_W-1:0]  e_dstE,
  output logic              e_Cnd,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_ccwr
);

  logic [3:0]        r_icode, r_ifun, r_stat;
  logic [WORD_W-1:0] r_valC, r_valA, r_valB;
  logic [REG_W-1:0]  r_dstE, r_dstM, r_srcA, r_srcB;
  logic              r_zf, r_sf, r_of;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_icode <= I_NOP;
      r_ifun  <= 4'h0;
      r_stat  <= AOK;
      r_valC  <= '0;
      r_valA  <= '0;
      r_valB  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_srcA  <= RNONE;
      r_srcB  <= RNONE;
    end else if (E_stall) begin
      // Hold; stall outranks bubble.
    end else if (E_bubble) begin
      r_icode <= I_NOP;
      r_ifun  <= 4'h0;
      r_stat  <= AOK;
      r_valC  <= '0;
      r_valA  <= '0;
      r_valB  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_srcA  <= RNONE;
      r_srcB  <= RNONE;
    end else begin
      r_icode <= d_icode;
      r_ifun  <= d_ifun;
      r_stat  <= d_stat;
      r_valC  <= d_valC;
      r_valA  <= d_valA;
      r_valB  <= d_valB;
      r_dstE  <= d_dstE;
      r_dstM  <= d_dstM;
      r_srcA  <= d_srcA;
      r_srcB  <= d_srcB;
    end
  end

  logic [WORD_W-1:0] w_alu_a, w_alu_b, w_alu_res;
  logic [3:0]        w_alufun;
  logic              w_alu_zf, w_alu_sf, w_alu_of;
  logic              w_set_cc, w_cnd;

  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    case (r_icode)
      I_RRMOVQ, I_OPQ:           w_alu_a = r_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = r_valC;
      I_CALL, I_PUSHQ:           w_alu_a = {{(WORD_W-4){1'b1}}, 4'b1000};
      I_RET, I_POPQ:             w_alu_a = WORD_W'(8);
      default: ;
    endcase
    case (r_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_alu_b = r_valB;
      default: ;
    endcase
  end

  assign w_alufun = (r_icode == I_OPQ) ? r_ifun : ALU_ADD;

  y86_alu u_alu (
    .i_alu_a  (w_alu_a),
    .i_alu_b  (w_alu_b),
    .i_alufun (w_alufun),
    .o_result (w_alu_res),
    .o_zf     (w_alu_zf),
    .o_sf     (w_alu_sf),
    .o_of     (w_alu_of)
  );

  // Undefined OPq functions never touch the CC.
  assign w_set_cc = (r_icode == I_OPQ) && (r_ifun <= ALU_XOR) && (r_stat == AOK) &&
                    !is_exc(m_stat) && !is_exc(W_stat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_set_cc) begin
      r_zf <= w_alu_zf;
      r_sf <= w_alu_sf;
      r_of <= w_alu_of;
    end
  end

  assign w_cnd = cond_eval(r_ifun, r_zf, r_sf, r_of);

  assign E_icode = r_icode;
  assign E_ifun  = r_ifun;
  assign E_stat  = r_stat;
  assign E_valA  = r_valA;
  assign E_dstM  = r_dstM;
  assign E_srcA  = r_srcA;
  assign E_srcB  = r_srcB;
  assign e_valE  = w_alu_res;
  assign e_Cnd   = w_cnd;
  assign e_dstE  = ((r_icode == I_RRMOVQ) && !w_cnd) ? RNONE : r_dstE;
  assign cc_zf   = r_zf;
  assign cc_sf   = r_sf;
  assign cc_of   = r_of;

`ifdef EXEC_PERF_CNT_EN
  logic [31:0] r_perf_bubbles, r_perf_ccwr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_bubbles <= '0;
      r_perf_ccwr    <= '0;
    end else begin
      if (E_bubble && !E_stall) r_perf_bubbles <= r_perf_bubbles + 32'd1;
      if (w_set_cc)             r_perf_ccwr    <= r_perf_ccwr + 32'd1;
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_ccwr    = r_perf_ccwr;
`else
  assign perf_bubbles = '0;
  assign perf_ccwr    = '0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios then randomized instructions
// compared against a behavioural model of the stage.
module tb_execute_stage;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  d_stat, d_icode, d_ifun;
  logic [63:0] d_valC, d_valA, d_valB;
  logic [3:0]  d_dstE, d_dstM, d_srcA, d_srcB;
  logic        E_stall, E_bubble;
  logic [3:0]  m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_stat;
  logic [63:0] E_valA, e_valE;
  logic [3:0]  E_dstM, E_srcA, E_srcB, e_dstE;
  logic        e_Cnd, cc_zf, cc_sf, cc_of;
  logic [31:0] perf_bubbles, perf_ccwr;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [3:0]  x_icode, x_ifun, x_stat, x_dstE, x_dstM, x_srcA, x_srcB;
  logic [63:0] x_valC, x_valA, x_valB;
  logic        x_zf, x_sf, x_of;
  logic [31:0] x_bub, x_ccwr;

  execute_stage dut (
    .clk          (clk),
    .rst          (rst),
    .d_stat       (d_stat),
    .d_icode      (d_icode),
    .d_ifun       (d_ifun),
    .d_valC       (d_valC),
    .d_valA       (d_valA),
    .d_valB       (d_valB),
    .d_dstE       (d_dstE),
    .d_dstM       (d_dstM),
    .d_srcA       (d_srcA),
    .d_srcB       (d_srcB),
    .E_stall      (E_stall),
    .E_bubble     (E_bubble),
    .m_stat       (m_stat),
    .W_stat       (W_stat),
    .E_icode      (E_icode),
    .E_ifun       (E_ifun),
    .E_stat       (E_stat),
    .E_valA       (E_valA),
    .E_dstM       (E_dstM),
    .E_srcA       (E_srcA),
    .E_srcB       (E_srcB),
    .e_valE       (e_valE),
    .e_dstE       (e_dstE),
    .e_Cnd        (e_Cnd),
    .cc_zf        (cc_zf),
    .cc_sf        (cc_sf),
    .cc_of        (cc_of),
    .perf_bubbles (perf_bubbles),
    .perf_ccwr    (perf_ccwr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What each instruction class computes, stated directly.
  function automatic logic [63:0] exp_val(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] c, input logic [63:0] a,
                                          input logic [63:0] b);
    case (ic)
      4'd2:        return a;
      4'd3:        return c;
      4'd4, 4'd5:  return b + c;
      4'd6: case (fn)
              4'd0:    return b + a;
              4'd1:    return b - a;
              4'd2:    return a & b;
              4'd3:    return a ^ b;
              default: return 64'd0;
            endcase
      4'd8, 4'd10: return b - 64'd8;
      4'd9, 4'd11: return b + 64'd8;
      default:     return 64'd0;
    endcase
  endfunction

  // Overflow = the exact 65-bit result does not fit in 64 signed bits.
  function automatic logic exp_of(input logic [3:0] fn, input logic [63:0] a,
                                  input logic [63:0] b);
    logic [64:0] s;
    s = 65'd0;
    if (fn == 4'd0) s = {a[63], a} + {b[63], b};
    else if (fn == 4'd1) s = {b[63], b} - {a[63], a};
    return s[64] ^ s[63];
  endfunction

  function automatic logic exp_cnd(input logic [3:0] fn, input logic z, input logic s,
                                   input logic o);
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (s ^ o) | z;
      4'd2:    return s ^ o;
      4'd3:    return z;
      4'd4:    return !z;
      4'd5:    return !(s ^ o);
      4'd6:    return !(s ^ o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_nop();
    x_icode = 4'd1; x_ifun = 4'd0; x_stat = 4'd1;
    x_valC = '0; x_valA = '0; x_valB = '0;
    x_dstE = 4'hF; x_dstM = 4'hF; x_srcA = 4'hF; x_srcB = 4'hF;
  endtask

  task automatic model_reset();
    model_nop();
    x_zf = 1'b1; x_sf = 1'b0; x_of = 1'b0;
    x_bub = '0; x_ccwr = '0;
  endtask

  task automatic model_step();
    logic [63:0] r;
    if (x_icode == 4'd6 && x_ifun < 4'd4 && x_stat == 4'd1 &&
        !(m_stat inside {4'd2, 4'd3, 4'd4}) && !(W_stat inside {4'd2, 4'd3, 4'd4})) begin
      r = exp_val(x_icode, x_ifun, x_valC, x_valA, x_valB);
      x_zf = (r == 64'd0);
      x_sf = r[63];
      x_of = exp_of(x_ifun, x_valA, x_valB);
      x_ccwr = x_ccwr + 32'd1;
    end
    if (E_stall) begin
    end else if (E_bubble) begin
      model_nop();
      x_bub = x_bub + 32'd1;
    end else begin
      x_icode = d_icode; x_ifun = d_ifun; x_stat = d_stat;
      x_valC = d_valC; x_valA = d_valA; x_valB = d_valB;
      x_dstE = d_dstE; x_dstM = d_dstM; x_srcA = d_srcA; x_srcB = d_srcB;
    end
  endtask

  task automatic check_all(input string tag);
    logic c;
    c = exp_cnd(x_ifun, x_zf, x_sf, x_of);
    chk({tag, ".icode"}, 64'(E_icode), 64'(x_icode));
    chk({tag, ".ifun"}, 64'(E_ifun), 64'(x_ifun));
    chk({tag, ".stat"}, 64'(E_stat), 64'(x_stat));
    chk({tag, ".valA"}, E_valA, x_valA);
    chk({tag, ".dstM"}, 64'(E_dstM), 64'(x_dstM));
    chk({tag, ".srcA"}, 64'(E_srcA), 64'(x_srcA));
    chk({tag, ".srcB"}, 64'(E_srcB), 64'(x_srcB));
    chk({tag, ".valE"}, e_valE, exp_val(x_icode, x_ifun, x_valC, x_valA, x_valB));
    chk({tag, ".cnd"}, 64'(e_Cnd), 64'(c));
    chk({tag, ".dstE"}, 64'(e_dstE), 64'((x_icode == 4'd2 && !c) ? 4'hF : x_dstE));
    chk({tag, ".cc"}, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, x_zf, x_sf, x_of});
`ifdef EXEC_PERF_CNT_EN
    chk({tag, ".pbub"}, 64'(perf_bubbles), 64'(x_bub));
    chk({tag, ".pccw"}, 64'(perf_ccwr), 64'(x_ccwr));
`else
    chk({tag, ".pbub"}, 64'(perf_bubbles), 64'd0);
    chk({tag, ".pccw"}, 64'(perf_ccwr), 64'd0);
`endif
  endtask

  task automatic set_d(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                       input logic [63:0] a, input logic [63:0] b, input logic [3:0] de);
    d_stat = 4'd1; d_icode = ic; d_ifun = fn;
    d_valC = c; d_valA = a; d_valB = b;
    d_dstE = de; d_dstM = 4'hF; d_srcA = 4'd1; d_srcB = 4'd2;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all(tag);
    chk({tag, ".icode1"}, 64'(E_icode), 64'd1);
    chk({tag, ".dstEF"}, 64'(e_dstE), 64'hF);
    chk({tag, ".zf1"}, 64'(cc_zf), 64'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'(signed'($urandom_range(0, 16)) - 8);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [3:0] rand_stat(input int unsigned bias);
    if ($urandom_range(0, bias) == 0) return 4'($urandom_range(2, 4));
    return 4'd1;
  endfunction

  initial begin
    int unsigned r;
    set_d(4'd1, 4'd0, '0, '0, '0, 4'hF);
    E_stall = 1'b0; E_bubble = 1'b0; m_stat = 4'd1; W_stat = 4'd1;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // OPq sub: 3 - 5
    set_d(4'd6, 4'd1, '0, 64'd5, 64'd3, 4'd2);
    cycle("sub");
    chk("sub_val", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    set_d(4'd1, 4'd0, '0, '0, '0, 4'hF);
    cycle("sub_cc");
    chk("sub_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b010);

    // Add overflow
    set_d(4'd6, 4'd0, '0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd2);
    cycle("addov");
    chk("addov_val", e_valE, 64'h8000_0000_0000_0000);
    set_d(4'd1, 4'd0, '0, '0, '0, 4'hF);
    cycle("addov_cc");
    chk("addov_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);

    // cmovle with ZF=SF=OF=0, then with ZF=1
    set_d(4'd6, 4'd0, '0, 64'd1, 64'd1, 4'd4);
    cycle("add11");
    set_d(4'd2, 4'd1, '0, 64'd7, '0, 4'd3);
    cycle("cmov_nt");
    chk("cmov_nt_cnd", 64'(e_Cnd), 64'd0);
    chk("cmov_nt_dst", 64'(e_dstE), 64'hF);
    set_d(4'd6, 4'd3, '0, 64'd5, 64'd5, 4'd4);
    cycle("xor55");
    set_d(4'd2, 4'd1, '0, 64'd7, '0, 4'd3);
    cycle("cmov_t");
    chk("cmov_t_dst", 64'(e_dstE), 64'd3);

    // CC write blocked by m_stat=ADR, then allowed
    set_d(4'd6, 4'd0, '0, 64'd1, 64'd1, 4'd4);
    cycle("add11b");
    set_d(4'd6, 4'd3, '0, 64'd9, 64'd9, 4'd4);
    cycle("xor99");
    m_stat = 4'd3;
    set_d(4'd1, 4'd0, '0, '0, '0, 4'hF);
    cycle("sup");
    chk("sup_zf", 64'(cc_zf), 64'd0);
    m_stat = 4'd1;
    set_d(4'd6, 4'd3, '0, 64'd9, 64'd9, 4'd4);
    cycle("xor99b");
    set_d(4'd1, 4'd0, '0, '0, '0, 4'hF);
    cycle("nosup");
    chk("nosup_zf", 64'(cc_zf), 64'd1);

    // Stall beats bubble; bubble alone inserts a nop
    set_d(4'd2, 4'd0, '0, 64'd11, '0, 4'd5);
    cycle("rr");
    set_d(4'd3, 4'd0, 64'd42, '0, '0, 4'd6);
    E_stall = 1'b1; E_bubble = 1'b1;
    cycle("stbub");
    chk("stbub_hold", 64'(E_icode), 64'd2);
    E_stall = 1'b0;
    cycle("bub");
    chk("bub_nop", 64'(E_icode), 64'd1);
`ifdef EXEC_PERF_CNT_EN
    chk("bub_cnt", 64'(perf_bubbles), 64'd1);
`endif
    E_bubble = 1'b0;

    mid_reset("midrst");

    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 15);
      d_icode  = (r > 11) ? ((r[0]) ? 4'd6 : 4'd2) : 4'(r);
      d_ifun   = (d_icode == 4'd6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      d_stat   = rand_stat(8);
      d_valC   = rand64();
      d_valA   = rand64();
      d_valB   = rand64();
      d_dstE   = 4'($urandom_range(0, 15));
      d_dstM   = 4'($urandom_range(0, 15));
      d_srcA   = 4'($urandom_range(0, 15));
      d_srcB   = 4'($urandom_range(0, 15));
      m_stat   = rand_stat(5);
      W_stat   = rand_stat(5);
      E_stall  = ($urandom_range(0, 9) == 0);
      E_bubble = ($urandom_range(0, 7) == 0);
      cycle("rnd");
      if (i == 250) mid_reset("rndrst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
